// File: rtl/ram_hex_dump_tx.sv
// Reads RAM[0..DUMP_DEPTH-1] and sends each byte as uppercase ASCII hex through a 16550-style UART.
// Optional DUMP_ADDR_PREFIX_EN: prefix every line with "AA: " (address of the line's first byte).
module ram_hex_dump_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MEM_ADD_WIDTH  = 8,
  parameter int unsigned DUMP_DEPTH     = 64,
  parameter int unsigned BYTES_PER_LINE = 8,
  parameter logic [15:0] BAUD_DIV       = 16'd14
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [MEM_ADD_WIDTH-1:0] sram_ADD_o,
  input  logic [DATA_WIDTH-1:0]    sram_DAT_i,
  output logic                     sram_CEN_o,
  output logic                     sram_WEN_o,
  output logic [2:0]               uart_addr_o,
  output logic [7:0]               uart_wdata_o,
  input  logic [7:0]               uart_rdata_i,
  output logic                     uart_we_o,
  output logic                     uart_re_o
);

  localparam int unsigned IDX_W  = MEM_ADD_WIDTH + 1;
  localparam int unsigned LINE_W = 8;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DUMP_DEPTH - 1);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(DUMP_DEPTH);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(BYTES_PER_LINE - 1);

  typedef enum logic [3:0] {
    IDLE, INIT_LCR1, INIT_DLL, INIT_DLM, INIT_LCR2,
    RD_REQ, RD_WAIT, POLL_REQ, POLL_WAIT, SEND, DONE
  } state_t;

  // Which character of the current byte's text is being sent
  typedef enum logic [3:0] {
`ifdef DUMP_ADDR_PREFIX_EN
    CH_P0, CH_P1, CH_P2, CH_P3,
`endif
    CH_HI, CH_LO, CH_CR, CH_LF, CH_SP
  } chr_t;

  state_t                r_state, w_state_d;
  chr_t                  r_chr, w_chr_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [LINE_W-1:0]     r_line, w_line_d;
  logic [7:0]            r_data, w_data_d;
  logic                  r_init_done, w_init_d;

  logic                     r_busy, w_busy_d;
  logic                     r_done, w_done_d;
  logic [MEM_ADD_WIDTH-1:0] r_add, w_add_d;
  logic                     r_cen, w_cen_d;
  logic [2:0]               r_uaddr, w_uaddr_d;
  logic [7:0]               r_wdata, w_wdata_d;
  logic                     r_we, w_we_d;
  logic                     r_re, w_re_d;

  logic       w_eol;
  logic [7:0] w_char;
  logic       w_lsr_unused;

  function automatic logic [7:0] hex_c(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_eol        = (r_line == LINE_LAST) || (r_idx == LAST_IDX);
  assign w_lsr_unused = ^{uart_rdata_i[7:6], uart_rdata_i[4:0]};

`ifdef DUMP_ADDR_PREFIX_EN
  logic [7:0] w_addr8;
  assign w_addr8 = 8'(r_idx);
`endif

  // Character selected for the next THR write
  always_comb begin
    w_char = 8'h20;
    case (r_chr)
`ifdef DUMP_ADDR_PREFIX_EN
      CH_P0:   w_char = hex_c(w_addr8[7:4]);
      CH_P1:   w_char = hex_c(w_addr8[3:0]);
      CH_P2:   w_char = 8'h3A;
      CH_P3:   w_char = 8'h20;
`endif
      CH_HI:   w_char = hex_c(r_data[7:4]);
      CH_LO:   w_char = hex_c(r_data[3:0]);
      CH_CR:   w_char = 8'h0D;
      CH_LF:   w_char = 8'h0A;
      CH_SP:   w_char = 8'h20;
      default: w_char = 8'h20;
    endcase
  end

  // Next state, datapath and registered-output decode
  always_comb begin
    w_state_d = r_state;
    w_chr_d   = r_chr;
    w_idx_d   = r_idx;
    w_line_d  = r_line;
    w_data_d  = r_data;
    w_init_d  = r_init_done;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    w_add_d   = r_add;
    w_cen_d   = 1'b1;
    w_uaddr_d = r_uaddr;
    w_wdata_d = r_wdata;
    w_we_d    = 1'b0;
    w_re_d    = 1'b0;

    case (r_state)
      IDLE: begin
        w_idx_d  = '0;
        w_line_d = '0;
        if (start) w_state_d = r_init_done ? RD_REQ : INIT_LCR1;
      end
      INIT_LCR1: w_state_d = INIT_DLL;
      INIT_DLL:  w_state_d = INIT_DLM;
      INIT_DLM:  w_state_d = INIT_LCR2;
      INIT_LCR2: begin
        w_init_d  = 1'b1;
        w_state_d = RD_REQ;
      end
      RD_REQ: w_state_d = RD_WAIT;
      RD_WAIT: begin
        w_data_d = 8'(sram_DAT_i);
`ifdef DUMP_ADDR_PREFIX_EN
        w_chr_d  = (r_line == '0) ? CH_P0 : CH_HI;
`else
        w_chr_d  = CH_HI;
`endif
        w_state_d = POLL_REQ;
      end
      POLL_REQ:  w_state_d = POLL_WAIT;
      POLL_WAIT: w_state_d = uart_rdata_i[5] ? SEND : POLL_REQ;
      SEND: begin
        w_state_d = POLL_REQ;
        case (r_chr)
`ifdef DUMP_ADDR_PREFIX_EN
          CH_P0: w_chr_d = CH_P1;
          CH_P1: w_chr_d = CH_P2;
          CH_P2: w_chr_d = CH_P3;
          CH_P3: w_chr_d = CH_HI;
`endif
          CH_HI: w_chr_d = CH_LO;
          CH_LO: w_chr_d = w_eol ? CH_CR : CH_SP;
          CH_CR: w_chr_d = CH_LF;
          default: begin
            // Last character of this byte's text
            w_idx_d   = r_idx + IDX_W'(1);
            w_line_d  = (r_chr == CH_LF) ? '0 : (r_line + LINE_W'(1));
            w_state_d = (w_idx_d == END_IDX) ? DONE : RD_REQ;
          end
        endcase
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase

    w_busy_d = (w_state_d != IDLE) && (w_state_d != DONE);
    w_done_d = (w_state_d == DONE);
    case (w_state_d)
      INIT_LCR1: begin w_we_d = 1'b1; w_uaddr_d = 3'd3; w_wdata_d = 8'h83; end
      INIT_DLL:  begin w_we_d = 1'b1; w_uaddr_d = 3'd0; w_wdata_d = BAUD_DIV[7:0]; end
      INIT_DLM:  begin w_we_d = 1'b1; w_uaddr_d = 3'd1; w_wdata_d = BAUD_DIV[15:8]; end
      INIT_LCR2: begin w_we_d = 1'b1; w_uaddr_d = 3'd3; w_wdata_d = 8'h03; end
      RD_REQ: begin
        w_cen_d = 1'b0;
        w_add_d = w_idx_d[MEM_ADD_WIDTH-1:0];
      end
      POLL_REQ:  begin w_re_d = 1'b1; w_uaddr_d = 3'd5; end
      SEND:      begin w_we_d = 1'b1; w_uaddr_d = 3'd0; w_wdata_d = w_char; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= IDLE;
      r_chr       <= CH_HI;
      r_idx       <= '0;
      r_line      <= '0;
      r_data      <= '0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_add       <= '0;
      r_cen       <= 1'b1;
      r_uaddr     <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_chr       <= w_chr_d;
      r_idx       <= w_idx_d;
      r_line      <= w_line_d;
      r_data      <= w_data_d;
      r_init_done <= w_init_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_add       <= w_add_d;
      r_cen       <= w_cen_d;
      r_uaddr     <= w_uaddr_d;
      r_wdata     <= w_wdata_d;
      r_we        <= w_we_d;
      r_re        <= w_re_d;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign sram_ADD_o   = r_add;
  assign sram_CEN_o   = r_cen;
  assign sram_WEN_o   = 1'b1;
  assign uart_addr_o  = r_uaddr;
  assign uart_wdata_o = r_wdata;
  assign uart_we_o    = r_we;
  assign uart_re_o    = r_re;

endmodule

// File: tb/tb_ram_hex_dump_tx.sv
// Scoreboard bench for ram_hex_dump_tx: RAM and UART register models, expected THR/RAM streams queued per dump.
module tb_ram_hex_dump_tx;

  localparam int DEPTH = 8;
  localparam int BPL   = 4;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [7:0] sram_ADD_o;
  logic [7:0] ram_q = 8'h00;
  logic       sram_CEN_o, sram_WEN_o;
  logic [2:0] uart_addr_o;
  logic [7:0] uart_wdata_o;
  logic [7:0] uart_rdata = 8'h00;
  logic       uart_we_o, uart_re_o;

  logic [7:0]  mem [0:255];
  logic [7:0]  lsr_q [$];
  logic [10:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  last_lsr = 8'h00;
  int          n_polls = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          polls_at_wr = 0;
  bit          sb_en = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  ram_hex_dump_tx #(
    .DATA_WIDTH(8), .MEM_ADD_WIDTH(8), .DUMP_DEPTH(DEPTH),
    .BYTES_PER_LINE(BPL), .BAUD_DIV(16'd14)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .busy(busy), .done(done),
    .sram_ADD_o(sram_ADD_o), .sram_DAT_i(ram_q), .sram_CEN_o(sram_CEN_o),
    .sram_WEN_o(sram_WEN_o), .uart_addr_o(uart_addr_o), .uart_wdata_o(uart_wdata_o),
    .uart_rdata_i(uart_rdata), .uart_we_o(uart_we_o), .uart_re_o(uart_re_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // RAM clocked on the falling edge
  always @(negedge CLK) if (!sram_CEN_o) ram_q <= mem[sram_ADD_o];

  // UART register model: LSR read data appears the cycle after re
  always @(posedge CLK) begin : uart_model
    logic [7:0] v;
    if (uart_re_o) begin
      v = (lsr_q.size() > 0) ? lsr_q.pop_front() : 8'h60;
      uart_rdata <= v;
      last_lsr   <= v;
      n_polls    <= n_polls + 1;
    end
  end

  always @(negedge CLK) begin : monitor
    logic [10:0] e;
    logic [7:0]  a;
    if (RESETn) begin
      if (done) n_done <= n_done + 1;
      if (uart_we_o && uart_re_o) check("we_re_excl", {uart_we_o, uart_re_o}, 2'b00);
      if (uart_we_o) begin
        n_wr <= n_wr + 1;
        if (n_polls != polls_at_wr) check("thre_before_wr", 32'(last_lsr[5]), 1);
        polls_at_wr <= n_polls;
      end
      if (sb_en && uart_we_o) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", {21'd0, uart_addr_o, uart_wdata_o}, 32'hFFFFFFFF);
        else begin
          e = exp_wr_q.pop_front();
          check("uart_wr", {21'd0, uart_addr_o, uart_wdata_o}, {21'd0, e});
        end
      end
      if (sb_en && !sram_CEN_o) begin
        check("sram_wen", 32'(sram_WEN_o), 1);
        if (exp_rd_q.size() == 0) check("rd_unexpected", {24'd0, sram_ADD_o}, 32'hFFFFFFFF);
        else begin
          a = exp_rd_q.pop_front();
          check("sram_add", {24'd0, sram_ADD_o}, {24'd0, a});
        end
      end
    end
  end

  task automatic push_wr(input logic [2:0] addr, input logic [7:0] data);
    exp_wr_q.push_back({addr, data});
  endtask

  task automatic push_dump(input bit with_init);
    if (with_init) begin
      push_wr(3'd3, 8'h83); push_wr(3'd0, 8'h0E); push_wr(3'd1, 8'h00); push_wr(3'd3, 8'h03);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      logic [7:0] ad;
      b  = mem[i];
      ad = 8'(i);
      exp_rd_q.push_back(ad);
`ifdef DUMP_ADDR_PREFIX_EN
      if (i % BPL == 0) begin
        push_wr(3'd0, hexc(ad[7:4])); push_wr(3'd0, hexc(ad[3:0]));
        push_wr(3'd0, 8'h3A); push_wr(3'd0, 8'h20);
      end
`endif
      push_wr(3'd0, hexc(b[7:4]));
      push_wr(3'd0, hexc(b[3:0]));
      if ((i % BPL == BPL - 1) || (i == DEPTH - 1)) begin
        push_wr(3'd0, 8'h0D); push_wr(3'd0, 8'h0A);
      end else push_wr(3'd0, 8'h20);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    #1 check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_add"}, 32'(sram_ADD_o), 0);
    check({tag, "_cen"}, 32'(sram_CEN_o), 1);
    check({tag, "_wen"}, 32'(sram_WEN_o), 1);
    check({tag, "_uaddr"}, 32'(uart_addr_o), 0);
    check({tag, "_wdata"}, 32'(uart_wdata_o), 0);
    check({tag, "_we"}, 32'(uart_we_o), 0);
    check({tag, "_re"}, 32'(uart_re_o), 0);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = n_done;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK); #1;
      if (n_done != d0) break;
    end
    check({tag, "_done_seen"}, 32'(n_done - d0), 1);
    repeat (3) @(negedge CLK);
    #1;
    check({tag, "_done_once"}, 32'(n_done - d0), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 0);
    check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 0);
  endtask

  initial begin
    int p0, w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("rst");
    @(negedge CLK) RESETn = 1'b1;

    // Dump 1: init sequence, then "00 01 02 03\r\n04 05 06 07\r\n"
    push_dump(1'b1);
    pulse_start();
    wait_done("run1");

    // Dump 2: no re-init, THRE held low for 5 polls before the first character
    mem[0] = 8'hAF;
    for (int i = 0; i < 5; i++) lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h20);
    push_dump(1'b0);
    p0 = n_polls;
    w0 = n_wr;
    pulse_start();
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK); #1;
      if (n_wr != w0) break;
    end
    check("polls_before_first_wr", 32'(n_polls - p0), 6);
    wait_done("run2");

    // Dump 3: async reset during a THR write, then a fresh start re-runs init
    sb_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK);
      if (uart_we_o && uart_addr_o == 3'd0) break;
    end
    check("send_reached", 32'(uart_we_o), 1);
    RESETn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge CLK) RESETn = 1'b1;
    lsr_q.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(negedge CLK) sb_en = 1'b1;
    push_dump(1'b1);
    pulse_start();
    wait_done("run3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
